// File: rtl/arp_engine.sv
// arp_engine
//   GMII-side ARP block. The TX half builds complete ARP request/reply frames
//   (preamble, Ethernet header, ARP payload with padding, CRC-32 FCS) and
//   streams them one byte per cycle. The RX half parses incoming GMII frames
//   and reports ARP requests/replies whose target IP is this board.
//   RX and TX run independently (full duplex) on the single gmii_clk.
//
// Ports
//   gmii_clk     in   clock for RX and TX (125 MHz)
//   rst          in   asynchronous reset, active-high
//   gmii_rx_dv   in   RX data valid
//   gmii_rxd     in   RX byte
//   gmii_tx_en   out  TX enable
//   gmii_txd     out  TX byte (00 while gmii_tx_en is low)
//   arp_rx_done  out  1-cycle pulse: accepted ARP frame
//   arp_rx_type  out  0 = request, 1 = reply (held after arp_rx_done)
//   src_mac      out  sender MAC of last accepted ARP frame
//   src_ip       out  sender IP of last accepted ARP frame
//   arp_tx_en    in   start pulse (ignored while a frame is in flight)
//   arp_tx_type  in   0 = request, 1 = reply, sampled with arp_tx_en
//   des_mac      in   target MAC for replies (0 selects DES_MAC)
//   des_ip       in   target IP (0 selects DES_IP)
//   tx_done      out  1-cycle pulse on the cycle gmii_tx_en falls
module arp_engine #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter logic [47:0] DES_MAC   = 48'hff_ff_ff_ff_ff_ff,
    parameter logic [31:0] DES_IP    = {8'd192, 8'd168, 8'd1, 8'd102}
) (
    input  logic        gmii_clk,
    input  logic        rst,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        arp_rx_done,
    output logic        arp_rx_type,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip,
    input  logic        arp_tx_en,
    input  logic        arp_tx_type,
    input  logic [47:0] des_mac,
    input  logic [31:0] des_ip,
    output logic        tx_done
);

    // One byte of the reflected IEEE 802.3 CRC-32 (poly EDB88320 in LSB-first form).
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    // ------------------------------------------------------------------
    // TX
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {TX_IDLE, TX_PREAMBLE, TX_ETH_HDR, TX_ARP_DATA, TX_FCS} tx_state_t;

    tx_state_t         tx_state, tx_next;
    logic [6:0]        tx_cnt;      // byte index within the 72-byte frame
    logic [31:0]       tx_crc;
    logic              tx_type_l;
    logic [47:0]       tx_mac_l;
    logic [31:0]       tx_ip_l;
    logic              tx_start;
    logic [47:0]       tx_eth_dest;
    logic [47:0]       tx_arp_tmac;
    logic [7:0]        tx_opcode;
    logic [59:0][7:0]  tx_frame;    // element 59 is the first byte after the SFD
    logic [5:0]        tx_bidx;
    logic [3:0][7:0]   tx_fcs;

    assign tx_start    = (tx_state == TX_IDLE) && arp_tx_en;
    assign tx_eth_dest = tx_type_l ? tx_mac_l : 48'hFFFF_FFFF_FFFF;
    assign tx_arp_tmac = tx_type_l ? tx_mac_l : 48'h0;
    assign tx_opcode   = tx_type_l ? 8'h02 : 8'h01;
    assign tx_frame    = {tx_eth_dest, BOARD_MAC, 16'h0806,
                          16'h0001, 16'h0800, 8'h06, 8'h04, 8'h00, tx_opcode,
                          BOARD_MAC, BOARD_IP, tx_arp_tmac, tx_ip_l, 144'h0};
    // Header/payload bytes occupy tx_cnt 8..67, mapped to elements 59..0.
    assign tx_bidx     = 6'(7'd67 - tx_cnt);
    // FCS goes out least-significant byte first; tx_cnt 68..71 -> [1:0] = 0..3.
    assign tx_fcs      = ~tx_crc;

    always_comb begin
        tx_next    = tx_state;
        gmii_tx_en = 1'b1;
        gmii_txd   = 8'h00;
        case (tx_state)
            TX_IDLE: begin
                gmii_tx_en = 1'b0;
                if (arp_tx_en) tx_next = TX_PREAMBLE;
            end
            TX_PREAMBLE: begin
                gmii_txd = (tx_cnt == 7'd7) ? 8'hD5 : 8'h55;
                if (tx_cnt == 7'd7) tx_next = TX_ETH_HDR;
            end
            TX_ETH_HDR: begin
                gmii_txd = tx_frame[tx_bidx];
                if (tx_cnt == 7'd21) tx_next = TX_ARP_DATA;
            end
            TX_ARP_DATA: begin
                gmii_txd = tx_frame[tx_bidx];
                if (tx_cnt == 7'd67) tx_next = TX_FCS;
            end
            TX_FCS: begin
                gmii_txd = tx_fcs[tx_cnt[1:0]];
                if (tx_cnt == 7'd71) tx_next = TX_IDLE;
            end
            default: begin
                gmii_tx_en = 1'b0;
                tx_next    = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge gmii_clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 7'd0;
            tx_crc   <= 32'hFFFF_FFFF;
            tx_done  <= 1'b0;
        end else begin
            tx_state <= tx_next;
            tx_done  <= (tx_state == TX_FCS) && (tx_cnt == 7'd71);
            tx_cnt   <= (tx_state == TX_IDLE) ? 7'd0 : tx_cnt + 7'd1;
            if (tx_state == TX_IDLE)
                tx_crc <= 32'hFFFF_FFFF;
            else if (tx_state == TX_ETH_HDR || tx_state == TX_ARP_DATA)
                tx_crc <= crc32_byte(tx_crc, gmii_txd);
        end
    end

    // Frame parameters are captured once at start so mid-frame input changes cannot corrupt it.
    always_ff @(posedge gmii_clk) begin
        if (tx_start) begin
            tx_type_l <= arp_tx_type;
            tx_mac_l  <= (des_mac == 48'h0) ? DES_MAC : des_mac;
            tx_ip_l   <= (des_ip == 32'h0) ? DES_IP : des_ip;
        end
    end

    // ------------------------------------------------------------------
    // RX
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {RX_IDLE, RX_PREAMBLE, RX_ETH_HDR, RX_ARP_DATA, RX_END} rx_state_t;

    rx_state_t    rx_state, rx_next;
    logic [4:0]   rx_cnt, rx_cnt_next;
    logic [167:0] rx_sh;        // last 21 bytes received; with gmii_rxd covers what is decoded
    logic         rx_accept;
    logic [47:0]  rx_eth_dest;
    logic [15:0]  rx_eth_type;
    logic [15:0]  rx_opcode;
    logic [47:0]  rx_snd_mac;
    logic [31:0]  rx_snd_ip;
    logic [31:0]  rx_tgt_ip;

    // Valid when the last header byte (ETH) or last target-IP byte (ARP) is on gmii_rxd.
    assign rx_eth_dest = rx_sh[103:56];
    assign rx_eth_type = {rx_sh[7:0], gmii_rxd};
    assign rx_opcode   = rx_sh[167:152];
    assign rx_snd_mac  = rx_sh[151:104];
    assign rx_snd_ip   = rx_sh[103:72];
    assign rx_tgt_ip   = {rx_sh[23:0], gmii_rxd};

    always_comb begin
        rx_next     = rx_state;
        rx_cnt_next = rx_cnt + 5'd1;
        rx_accept   = 1'b0;
        if (!gmii_rx_dv) begin
            rx_next     = RX_IDLE;
            rx_cnt_next = 5'd0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt_next = 5'd1;
                    rx_next     = (gmii_rxd == 8'h55) ? RX_PREAMBLE : RX_END;
                end
                RX_PREAMBLE: begin
                    if (rx_cnt == 5'd7) begin
                        rx_cnt_next = 5'd0;
                        rx_next     = (gmii_rxd == 8'hD5) ? RX_ETH_HDR : RX_END;
                    end else if (gmii_rxd != 8'h55) begin
                        rx_next = RX_END;
                    end
                end
                RX_ETH_HDR: begin
                    if (rx_cnt == 5'd13) begin
                        rx_cnt_next = 5'd0;
                        if ((rx_eth_dest == BOARD_MAC || rx_eth_dest == 48'hFFFF_FFFF_FFFF) &&
                            rx_eth_type == 16'h0806)
                            rx_next = RX_ARP_DATA;
                        else
                            rx_next = RX_END;
                    end
                end
                RX_ARP_DATA: begin
                    if (rx_cnt == 5'd27) begin
                        rx_next   = RX_END;
                        rx_accept = (rx_opcode == 16'd1 || rx_opcode == 16'd2) &&
                                    (rx_tgt_ip == BOARD_IP);
                    end
                end
                default: rx_next = rx_state;   // RX_END: hold until gmii_rx_dv drops
            endcase
        end
    end

    always_ff @(posedge gmii_clk or posedge rst) begin
        if (rst) begin
            rx_state    <= RX_IDLE;
            rx_cnt      <= 5'd0;
            arp_rx_done <= 1'b0;
            arp_rx_type <= 1'b0;
            src_mac     <= 48'h0;
            src_ip      <= 32'h0;
        end else begin
            rx_state    <= rx_next;
            rx_cnt      <= rx_cnt_next;
            arp_rx_done <= rx_accept;
            if (rx_accept) begin
                arp_rx_type <= (rx_opcode == 16'd2);
                src_mac     <= rx_snd_mac;
                src_ip      <= rx_snd_ip;
            end
        end
    end

    always_ff @(posedge gmii_clk) begin
        rx_sh <= {rx_sh[159:0], gmii_rxd};
    end

endmodule

// File: tb/tb_arp_engine.sv
module tb_arp_engine;

    logic        gmii_clk = 1'b0;
    logic        rst;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;
    logic        arp_rx_done;
    logic        arp_rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        tx_done;

    // Loopback TX -> RX unless the bench injects its own frames.
    logic        inj = 1'b0;
    logic        inj_dv = 1'b0;
    logic [7:0]  inj_d = 8'h00;
    assign gmii_rx_dv = inj ? inj_dv : gmii_tx_en;
    assign gmii_rxd   = inj ? inj_d  : gmii_txd;

    arp_engine #(
        .BOARD_MAC (48'h00_11_22_33_44_55),
        .BOARD_IP  (32'hC0A8_0166),
        .DES_MAC   (48'hff_ff_ff_ff_ff_ff),
        .DES_IP    (32'hC0A8_0166)
    ) dut (
        .gmii_clk    (gmii_clk),
        .rst         (rst),
        .gmii_rx_dv  (gmii_rx_dv),
        .gmii_rxd    (gmii_rxd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_txd    (gmii_txd),
        .arp_rx_done (arp_rx_done),
        .arp_rx_type (arp_rx_type),
        .src_mac     (src_mac),
        .src_ip      (src_ip),
        .arp_tx_en   (arp_tx_en),
        .arp_tx_type (arp_tx_type),
        .des_mac     (des_mac),
        .des_ip      (des_ip),
        .tx_done     (tx_done)
    );

    always #4 gmii_clk = ~gmii_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge gmii_clk);
        #1;
    endtask

    // Monitor: capture each TX burst, count pulses, watch idle bus and tx_done alignment.
    logic [7:0] tx_q[$];
    int   tx_done_cnt = 0;
    int   rx_done_cnt = 0;
    int   idle_bad = 0;
    int   done_bad = 0;
    logic prev_en = 1'b0;

    always @(negedge gmii_clk) begin
        if (gmii_tx_en && !prev_en) tx_q.delete();
        if (gmii_tx_en) tx_q.push_back(gmii_txd);
        else if (gmii_txd !== 8'h00) idle_bad++;
        if (tx_done) begin
            tx_done_cnt++;
            if (gmii_tx_en || !prev_en) done_bad++;
        end
        if (arp_rx_done) rx_done_cnt++;
        prev_en = gmii_tx_en;
    end

    // Expected frames, written out byte by byte (header + ARP payload, 60 bytes).
    localparam logic [479:0] REQ_BODY = {336'hFFFFFFFFFFFF_001122334455_0806_0001_0800_06_04_0001_001122334455_C0A80166_000000000000_C0A80166, 144'h0};
    localparam logic [479:0] REP_BODY = {336'h001122334455_001122334455_0806_0001_0800_06_04_0002_001122334455_C0A80166_001122334455_C0A80166, 144'h0};

    logic [7:0] exp_f[72];
    logic [7:0] inj_buf[72];

    // Reference FCS: MSB-first CRC-32 (poly 04C11DB7) fed data LSB first, then reflected.
    task automatic build_exp(input logic [479:0] body);
        logic [31:0] c;
        logic [31:0] r;
        logic        fb;
        for (int i = 0; i < 7; i++) exp_f[i] = 8'h55;
        exp_f[7] = 8'hD5;
        for (int e = 0; e < 60; e++) exp_f[8+e] = body[479-8*e -: 8];
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < 68; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[31] ^ exp_f[i][b];
                c  = c << 1;
                if (fb) c = c ^ 32'h04C1_1DB7;
            end
        end
        for (int k = 0; k < 32; k++) r[k] = c[31-k];
        r = ~r;
        exp_f[68] = r[7:0];
        exp_f[69] = r[15:8];
        exp_f[70] = r[23:16];
        exp_f[71] = r[31:24];
    endtask

    task automatic check_frame(input string nm);
        chk({nm, "_len"}, 64'(tx_q.size()), 64'd72);
        for (int i = 0; i < 72 && i < tx_q.size(); i++)
            chk($sformatf("%s_b%0d", nm, i), 64'(tx_q[i]), 64'(exp_f[i]));
    endtask

    task automatic start_tx(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
        arp_tx_en   = 1'b1;
        arp_tx_type = typ;
        des_mac     = mac;
        des_ip      = ip;
        tick();
        arp_tx_en   = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (tx_done_cnt < target && n < 300) begin
            tick();
            n++;
        end
        if (tx_done_cnt < target) chk("tx_done_timeout", 64'(tx_done_cnt), 64'(target));
        repeat (2) tick();
    endtask

    // Sends inj_buf followed by a single idle cycle.
    task automatic send_frame();
        for (int i = 0; i < 72; i++) begin
            inj_dv = 1'b1;
            inj_d  = inj_buf[i];
            tick();
        end
        inj_dv = 1'b0;
        inj_d  = 8'h00;
        tick();
    endtask

    initial begin
        arp_tx_en   = 1'b0;
        arp_tx_type = 1'b0;
        des_mac     = 48'h0;
        des_ip      = 32'h0;
        rst         = 1'b0;
        #1 rst      = 1'b1;
        repeat (3) tick();

        chk("rst_tx_en",   64'(gmii_tx_en),  64'd0);
        chk("rst_txd",     64'(gmii_txd),    64'd0);
        chk("rst_rx_done", 64'(arp_rx_done), 64'd0);
        chk("rst_rx_type", 64'(arp_rx_type), 64'd0);
        chk("rst_src_mac", 64'(src_mac),     64'd0);
        chk("rst_src_ip",  64'(src_ip),      64'd0);
        chk("rst_tx_done", 64'(tx_done),     64'd0);

        rst = 1'b0;
        repeat (20) tick();
        chk("idle_no_tx",   64'(tx_q.size()),  64'd0);
        chk("idle_no_done", 64'(tx_done_cnt),  64'd0);

        // Request with fallback target IP, looped back into RX
        start_tx(1'b0, 48'h0, 32'h0);
        chk("req_latency", 64'(gmii_tx_en), 64'd1);
        wait_done(1);
        build_exp(REQ_BODY);
        check_frame("req");
        chk("req_done_cnt",  64'(tx_done_cnt), 64'd1);
        chk("req_rx_cnt",    64'(rx_done_cnt), 64'd1);
        chk("req_rx_type",   64'(arp_rx_type), 64'd0);
        chk("req_src_mac",   64'(src_mac),     64'h0011_2233_4455);
        chk("req_src_ip",    64'(src_ip),      64'hC0A8_0166);

        // Reply to the learned MAC
        repeat (100) tick();
        start_tx(1'b1, src_mac, 32'h0);
        wait_done(2);
        build_exp(REP_BODY);
        check_frame("rep");
        chk("rep_done_cnt", 64'(tx_done_cnt), 64'd2);
        chk("rep_rx_cnt",   64'(rx_done_cnt), 64'd2);
        chk("rep_rx_type",  64'(arp_rx_type), 64'd1);

        // Filtering: rejected frames back to back, one idle cycle apart
        inj = 1'b1;
        for (int k = 0; k < 5; k++) begin
            inj_buf = exp_f;
            case (k)
                0:       inj_buf[49] = 8'h01;   // target IP C0A80101
                1:       inj_buf[21] = 8'h00;   // ethertype 0800
                2:       inj_buf[7]  = 8'hD4;   // bad SFD
                3:       inj_buf[8]  = 8'h02;   // eth dest neither us nor broadcast
                default: inj_buf[29] = 8'h03;   // unsupported opcode
            endcase
            send_frame();
        end
        chk("flt_rx_cnt",  64'(rx_done_cnt), 64'd2);
        chk("flt_src_mac", 64'(src_mac),     64'h0011_2233_4455);
        chk("flt_src_ip",  64'(src_ip),      64'hC0A8_0166);
        chk("flt_rx_type", 64'(arp_rx_type), 64'd1);

        // Accepted injected request from another sender
        inj_buf = exp_f;
        inj_buf[29] = 8'h01;
        inj_buf[30] = 8'hAA; inj_buf[31] = 8'hBB; inj_buf[32] = 8'hCC;
        inj_buf[33] = 8'hDD; inj_buf[34] = 8'hEE; inj_buf[35] = 8'h01;
        inj_buf[36] = 8'hC0; inj_buf[37] = 8'hA8; inj_buf[38] = 8'h01; inj_buf[39] = 8'h07;
        send_frame();
        chk("inj_rx_cnt",  64'(rx_done_cnt), 64'd3);
        chk("inj_rx_type", 64'(arp_rx_type), 64'd0);
        chk("inj_src_mac", 64'(src_mac),     64'hAABB_CCDD_EE01);
        chk("inj_src_ip",  64'(src_ip),      64'hC0A8_0107);
        inj = 1'b0;

        // Start pulse while busy is ignored
        repeat (5) tick();
        start_tx(1'b0, 48'h0, 32'h0);
        repeat (20) tick();
        start_tx(1'b1, 48'h0A0B_0C0D_0E0F, 32'h0A00_0001);
        wait_done(3);
        build_exp(REQ_BODY);
        check_frame("busy");
        chk("busy_done_cnt", 64'(tx_done_cnt), 64'd3);
        repeat (10) tick();
        chk("busy_no_restart", 64'(gmii_tx_en), 64'd0);

        // Reset mid-frame
        start_tx(1'b0, 48'h0, 32'h0);
        repeat (30) tick();
        chk("pre_rst_tx_en", 64'(gmii_tx_en), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_en", 64'(gmii_tx_en), 64'd0);
        chk("mid_rst_txd",   64'(gmii_txd),   64'd0);
        tick();
        rst = 1'b0;
        repeat (120) tick();
        chk("mid_rst_no_done", 64'(tx_done_cnt), 64'd3);
        chk("mid_rst_idle",    64'(gmii_tx_en),  64'd0);

        chk("idle_txd_zero",   64'(idle_bad), 64'd0);
        chk("done_alignment",  64'(done_bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
